// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 keyboard receiver in the system clock domain.
// Synchronizes raw ps2_clk/ps2_data, frames 11-bit packets (start, 8 data
// LSB first, parity, stop) with a per-bit timeout, folds E0/F0 prefixes into
// single key events and queues them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   ps2_clk, ps2_data   raw asynchronous keyboard lines
//   ev_code/ev_release/ev_extended/ev_valid, ev_ready   event stream (head of FIFO)
//   reset_required      one-cycle pulse on a received 0xAA
//   frame_error         one-cycle pulse on framing/parity/timeout/keyboard error
//   overflow            one-cycle pulse when an event is dropped on a full FIFO
//
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise
// the parity bit is received but ignored.
module ps2_key_event_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ev_code,
  output logic       ev_release,
  output logic       ev_extended,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       reset_required,
  output logic       frame_error,
  output logic       overflow
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EV_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   clk_s, data_s, fall;

  // Frame FSM
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]  shift_q, shift_d;
  logic        byte_stb_q, byte_stb_d;
  logic [7:0]  byte_q, byte_d;
  logic        par_ok, frame_ok, fsm_err;

  // Prefix decoder
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic        push, dec_err;
  logic [EV_W-1:0] push_data;

  // FIFO
  logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
  logic [EV_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop, full, do_push;

  // Registered outputs
  logic [EV_W-1:0] head_q, head_d;
  logic            ev_valid_q, ev_valid_d;
  logic            rr_q, rr_d;
  logic            fe_q, fe_d;
  logic            ovf_q, ovf_d;

  // Shift raw lines in; a falling edge compares the last two synced samples
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    clk_prev_d  = clk_s;
    fall        = clk_prev_q & ~clk_s;
  end

  // shift_q after 10 edges: [7:0] data, [8] parity, [9] stop
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^shift_q[8:0];
`else
  assign par_ok = 1'b1;
`endif
  assign frame_ok = shift_q[9] & par_ok;

  // Frame FSM next state
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    byte_stb_d = 1'b0;
    byte_d     = byte_q;
    fsm_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          if (!data_s) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = 4'd0;
            tmo_d     = '0;
          end else begin
            fsm_err = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          shift_d = {data_s, shift_q[9:1]};
          tmo_d   = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          fsm_err   = 1'b1;
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          byte_stb_d = 1'b1;
          byte_d     = shift_q[7:0];
        end else begin
          fsm_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prefix decoder: prefixes only set flags, every other byte consumes them
  always_comb begin
    ext_d     = ext_q;
    rel_d     = rel_q;
    push      = 1'b0;
    dec_err   = 1'b0;
    rr_d      = 1'b0;
    push_data = {ext_q, rel_q, byte_q};
    if (byte_stb_q) begin
      case (byte_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'hAA: begin
          rr_d  = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        8'h00, 8'hFF: begin
          dec_err = 1'b1;
          ext_d   = 1'b0;
          rel_d   = 1'b0;
        end
        default: begin
          push  = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      endcase
    end
  end

  // FIFO: a pop frees the slot a same-cycle push needs when full
  always_comb begin
    pop      = ev_valid_q & ev_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    do_push  = push & (~full | pop);
    ovf_d    = push & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    ev_valid_d = (count_d != '0);
    head_d     = ev_valid_d ? mem_d[rd_ptr_d] : '0;
    fe_d       = fsm_err | dec_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      tmo_q       <= '0;
      shift_q     <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'd0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      ev_valid_q  <= 1'b0;
      rr_q        <= 1'b0;
      fe_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      ev_valid_q  <= ev_valid_d;
      rr_q        <= rr_d;
      fe_q        <= fe_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ev_code        = head_q[7:0];
  assign ev_release     = head_q[8];
  assign ev_extended    = head_q[9];
  assign ev_valid       = ev_valid_q;
  assign reset_required = rr_q;
  assign frame_error    = fe_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- System-clock controller that sequences PS/2 keyboard reception: synchronizes raw ps2_clk/ps2_data and frames 11-bit packets with parity, stop and timeout checks.
- Resolves E0/F0 prefix sequences into single key events and buffers them in a small FIFO behind a valid/ready handshake.
- Sits between the keyboard pins and the rest of the system; replaces direct ps2_clk-domain latching with a single-clock, flow-controlled event stream.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles allowed between ps2_clk falling edges inside a frame before abort (1 ms at 50 MHz).
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on ps2_clk and ps2_data; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous.
- ps2_data  input  1  raw keyboard data, asynchronous.
- ev_code  output  8  scancode of the FIFO head event.
- ev_release  output  1  head event was F0-prefixed.
- ev_extended  output  1  head event was E0-prefixed.
- ev_valid  output  1  FIFO non-empty.
- ev_ready  input  1  consumer accepts the head event when ev_valid && ev_ready.
- reset_required  output  1  one-cycle pulse when 0xAA is received.
- frame_error  output  1  one-cycle pulse on a bad start/parity/stop bit or a timeout.
- overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset: clk and rst only; rst low sampled on a clk edge is the sole reset.
  - Synchronizer flops reset to 1.
  - Frame FSM goes to IDLE; prefix flags cleared; FIFO emptied.
  - All outputs 0; ev_code, ev_release and ev_extended read 0 while the FIFO is empty.
  - Reset mid-frame discards the partial frame and any pending prefixes; no event or error results.
- Synchronizer and edge detect:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge is synced ps2_clk 1 -> 0 between consecutive clk cycles.
  - Data is sampled from synced ps2_data in the same cycle as the edge.
- Frame FSM, states IDLE, SHIFT, CHECK:
  - IDLE, falling edge with data 0: go to SHIFT, bit counter = 0, timeout counter = 0.
  - IDLE, falling edge with data 1: pulse frame_error, stay in IDLE.
  - SHIFT: each falling edge stores one bit. 8 data bits LSB first, then parity, then stop. The 10th edge moves to CHECK.
  - SHIFT timeout: the counter clears on every falling edge. If it reaches TIMEOUT_CYCLES-1 with no edge, pulse frame_error and go to IDLE with the bit count discarded.
  - CHECK lasts exactly 1 cycle, then returns to IDLE. Pass if data^parity has odd weight and stop = 1. Pass issues a byte strobe to the decoder; fail pulses frame_error.
- Prefix decoder, runs in the cycle after CHECK:
  - 0xE0 sets the ext flag; 0xF0 sets the rel flag.
  - 0xAA pulses reset_required and clears both flags.
  - 0x00 and 0xFF (keyboard error codes) pulse frame_error and clear both flags.
  - Any other byte pushes {ext, rel, byte} to the FIFO and clears both flags.
  - A repeated prefix is idempotent: E0 E0 74 yields one extended event.
- FIFO:
  - Registered, first-word-fall-through. Head fields and ev_valid change only on clk edges.
  - Pop occurs when ev_valid && ev_ready.
  - Push while full: the event is dropped, overflow pulses and flags still clear.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a separate count, or an extra pointer bit, distinguishes full from empty.
- Latency: let N be the cycle the synchronized stop-bit falling edge is detected. CHECK occurs at N+1, the FIFO write at N+2, and ev_valid rises at N+3 (FIFO previously empty).
- Same-cycle pulses: reset_required, frame_error and overflow never need to coincide in one cycle; at most one byte reaches the decoder per frame.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: odd parity is enforced in CHECK as above.
- Undefined: the parity bit is shifted in but ignored. CHECK tests only the stop bit, so a frame with bad parity produces an event instead of frame_error.

Test Plan:
- Frame 0x1C with parity 0, stop 1, ev_ready = 1 -> one ev_valid cycle at N+3, ev_code = 0x1C, release = 0, extended = 0; no error pulses.
- Frames E0, F0, 74, ev_ready held 0 -> exactly one entry {ext = 1, rel = 1, code = 0x74}; after ev_ready = 1, ev_valid drops the next cycle.
- Frame 0x1C with parity 1 -> frame_error pulse, no event when PS2_PARITY_CHECK_EN is defined; event 0x1C when it is undefined.
- Frame 0xAA -> reset_required high exactly 1 cycle, FIFO unchanged. Then 4 data bits followed by silence of TIMEOUT_CYCLES -> frame_error pulse, FSM back in IDLE, and the next frame 0x15 decodes correctly.
- FIFO_DEPTH+1 frames 0x16..0x1A with ev_ready = 0 -> one overflow pulse on 0x1A. Draining yields 0x16..0x19 in order, then ev_valid = 0.
- rst low after 5 bits of a frame, then a full 0x1C frame -> no event from the partial frame, one event 0x1C; all outputs 0 during reset.
